// File: rtl/cheat_slot_scheduler.sv
// Time-shared decoder for the cheat digit buffer plus the registered cartridge
// substitution lookup that serves from the atomically committed slot table.
module cheat_slot_scheduler #(
    parameter int        NUM_SLOTS       = 3,
    parameter int        DIGITS_PER_SLOT = 5,
    parameter logic [7:0] BLANK_CODE     = 8'h02
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      showCheatUI,
    input  logic [NUM_SLOTS*40-1:0]   cheatDigits,
    input  logic [12:0]               cartAddress,
    input  logic                      cartSample,
    output logic                      overrideActive,
    output logic [7:0]                overrideData,
    output logic [NUM_SLOTS-1:0]      slotValid,
    output logic                      scanBusy,
    output logic [2:0]                debugState
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [2:0]        LAST_DIG  = 3'(DIGITS_PER_SLOT - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SCAN         = 3'd1,
        COMMIT       = 3'd2,
        FINAL_SCAN   = 3'd3,
        FINAL_COMMIT = 3'd4
    } state_t;

    state_t state, nextState;
    logic [SLOT_W-1:0] slotIdx;
    logic [2:0]        digIdx;
    logic              scanStep, restart, commitNow, lastDigit;

    logic [7:0]  digitArr [NUM_SLOTS][DIGITS_PER_SLOT];
    logic [7:0]  digitByte;
    logic [3:0]  nibble;
    logic        isBlank;

    logic [11:0]          shAddr [NUM_SLOTS];
    logic [7:0]           shData [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] shValid;
    logic [11:0]          cmAddr [NUM_SLOTS];
    logic [7:0]           cmData [NUM_SLOTS];

    logic       hit, matchQualified, matchActive;
    logic [7:0] hitData, matchData;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : gUnpackSlot
        for (genvar d = 0; d < DIGITS_PER_SLOT; d++) begin : gUnpackDigit
            assign digitArr[s][d] = cheatDigits[(s*DIGITS_PER_SLOT+d)*8 +: 8];
        end
    end

    assign digitByte = digitArr[slotIdx][digIdx];
    assign nibble    = digitByte[4:1] - 4'd2;
    assign isBlank   = (digitByte == BLANK_CODE);
    assign lastDigit = (slotIdx == LAST_SLOT) && (digIdx == LAST_DIG);

    always_comb begin
        nextState = state;
        scanStep  = 1'b0;
        restart   = 1'b0;
        commitNow = 1'b0;
        case (state)
            IDLE: if (showCheatUI) nextState = SCAN;
            SCAN: begin
                if (showCheatUI) begin
                    scanStep = 1'b1;
                    if (lastDigit) nextState = COMMIT;
                end else if (slotIdx == '0 && digIdx == 3'd0) begin
                    // Nothing scanned yet: this cycle already is the start of a fresh final pass.
                    scanStep  = 1'b1;
                    nextState = FINAL_SCAN;
                end else begin
                    restart   = 1'b1;
                    nextState = FINAL_SCAN;
                end
            end
            FINAL_SCAN: begin
                scanStep = 1'b1;
                if (lastDigit) nextState = FINAL_COMMIT;
            end
            COMMIT, FINAL_COMMIT: begin
                commitNow = 1'b1;
                nextState = showCheatUI ? SCAN : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            slotIdx <= '0;
            digIdx  <= '0;
        end else begin
            state <= nextState;
            if (restart || (scanStep && lastDigit)) begin
                slotIdx <= '0;
                digIdx  <= '0;
            end else if (scanStep) begin
                if (digIdx == LAST_DIG) begin
                    slotIdx <= slotIdx + 1'b1;
                    digIdx  <= '0;
                end else begin
                    digIdx <= digIdx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                shAddr[s] <= '0;
                shData[s] <= '0;
                cmAddr[s] <= '0;
                cmData[s] <= '0;
            end
            shValid   <= '0;
            slotValid <= '0;
        end else begin
            if (scanStep) begin
                case (digIdx)
                    3'd0:    shAddr[slotIdx][11:8] <= nibble;
                    3'd1:    shAddr[slotIdx][7:4]  <= nibble;
                    3'd2:    shAddr[slotIdx][3:0]  <= nibble;
                    3'd3:    shData[slotIdx][7:4]  <= nibble;
                    default: shData[slotIdx][3:0]  <= nibble;
                endcase
                // Valid is re-armed at the first digit; any blank digit then kills the slot.
                if (digIdx == 3'd0)
                    shValid[slotIdx] <= !isBlank;
                else if (isBlank)
                    shValid[slotIdx] <= 1'b0;
            end
            if (commitNow) begin
                cmAddr    <= shAddr;
                cmData    <= shData;
                slotValid <= shValid;
            end
        end
    end

    // Descending walk so the lowest matching slot index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hitData = 8'h00;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slotValid[s] && cmAddr[s] == cartAddress[11:0]) begin
                hit     = 1'b1;
                hitData = cmData[s];
            end
        end
    end

    assign matchQualified = !showCheatUI && !scanBusy && cartAddress[12] && hit;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            matchActive <= 1'b0;
            matchData   <= 8'h00;
        end else if (cartSample) begin
            matchActive <= matchQualified;
            matchData   <= matchQualified ? hitData : 8'h00;
        end
    end

    assign scanBusy       = (state != IDLE);
    assign overrideActive = matchActive && !showCheatUI && !scanBusy;
    assign overrideData   = matchData;
    assign debugState     = state;

endmodule
